// File: rtl/ysyx_23060096_lsu_if.sv
// Bundle of the LSU's EXU-side request/response and memory-side bus signals.
// master: the environment (EXU plus memory); slave: the LSU itself.
interface ysyx_23060096_lsu_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // EXU request
  logic              req_valid;
  logic              req_ready;
  logic              MemWr;
  logic              MemtoReg;
  logic [2:0]        MemOP;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;

  // WBU response
  logic              resp_valid;
  logic [DW-1:0]     rdata;
  logic              err;

  // Memory port
  logic              mem_req;
  logic              mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport master (
    output req_valid, MemWr, MemtoReg, MemOP, addr, wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, rdata, err,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    input  req_valid, MemWr, MemtoReg, MemOP, addr, wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, rdata, err,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060096_lsu.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid memory port,
// byte-lane formatting of stores and lane extraction/extension of loads.
// Optional feature: define YSYX_23060096_LSU_MISALIGN_EN to trap misaligned
// half/word accesses (err=1, no memory request); otherwise err stays 0 and
// misaligned accesses are issued using the normal lane rules.
module ysyx_23060096_lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic                clk,
  input logic                rst,
  ysyx_23060096_lsu_if.slave bus
);

  localparam int unsigned NB = DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Access size from MemOP; unlisted codes behave as word
  function automatic size_t op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      lo_q, lo_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wen_q, mem_wen_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_wmask_q, mem_wmask_d;

  logic            access_c;
  logic            misalign_c;
  logic [NB-1:0]   st_mask_c;
  logic [DW-1:0]   st_wdata_c;
  logic [7:0]      lane_b_c;
  logic [15:0]     lane_h_c;
  logic [DW-1:0]   load_ext_c;

  // Store formatting and alignment check on the incoming request
  always_comb begin
    access_c   = bus.MemWr | bus.MemtoReg;
    st_mask_c  = {NB{1'b1}};
    st_wdata_c = bus.wdata;
    misalign_c = 1'b0;
    case (op_size(bus.MemOP))
      SZ_B: begin
        st_mask_c  = NB'(4'b0001 << bus.addr[1:0]);
        st_wdata_c = {NB{bus.wdata[7:0]}};
      end
      SZ_H: begin
        st_mask_c  = NB'(4'b0011 << {bus.addr[1], 1'b0});
        st_wdata_c = {(NB/2){bus.wdata[15:0]}};
      end
      default: begin
        st_mask_c  = {NB{1'b1}};
        st_wdata_c = bus.wdata;
      end
    endcase
`ifdef YSYX_23060096_LSU_MISALIGN_EN
    case (op_size(bus.MemOP))
      SZ_H:    misalign_c = access_c & bus.addr[0];
      SZ_W:    misalign_c = access_c & (bus.addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
`endif
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    lane_b_c = bus.mem_rdata[7:0];
    case (lo_q)
      2'b01:   lane_b_c = bus.mem_rdata[15:8];
      2'b10:   lane_b_c = bus.mem_rdata[23:16];
      2'b11:   lane_b_c = bus.mem_rdata[31:24];
      default: lane_b_c = bus.mem_rdata[7:0];
    endcase
    lane_h_c = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_size(op_q))
      SZ_B: load_ext_c = op_q[2] ? {{(DW-8){1'b0}}, lane_b_c}
                                 : {{(DW-8){lane_b_c[7]}}, lane_b_c};
      SZ_H: load_ext_c = op_q[2] ? {{(DW-16){1'b0}}, lane_h_c}
                                 : {{(DW-16){lane_h_c[15]}}, lane_h_c};
      default: load_ext_c = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.MemOP;
          lo_d = bus.addr[1:0];
          if (access_c && !misalign_c) begin
            state_d     = REQ;
            mem_wen_d   = bus.MemWr;
            mem_addr_d  = {bus.addr[AW-1:2], 2'b00};
            mem_wdata_d = bus.MemWr ? st_wdata_c : '0;
            mem_wmask_d = bus.MemWr ? st_mask_c : '0;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = misalign_c;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (mem_wen_q) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = RESP;
          rdata_d = load_ext_c;
          err_d   = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_req_d    = (state_d == REQ);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      lo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// Scoreboard bench for ysyx_23060096_lsu: a driver plays EXU and memory and
// queues expected responses; independent monitors compare what the DUT shows.
module tb_ysyx_23060096_lsu;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060096_lsu_if #(.AW(AW), .DW(DW)) bus ();

  ysyx_23060096_lsu #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_exp_t;

  resp_exp_t resp_q[$];
  mem_exp_t  mem_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected at cycle %0d", name, cyc);
  endtask

  // Response monitor and memory-request monitor
  initial begin
    resp_exp_t re;
    mem_exp_t  me;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.resp_valid) begin
          if (resp_q.size() == 0) flag("spurious_resp_valid");
          else begin
            re = resp_q.pop_front();
            check32("resp_cycle", 32'(cyc), 32'(re.at));
            check32("rdata", bus.rdata, re.rdata);
            check32("err", 32'(bus.err), 32'(re.err));
          end
        end
        if (bus.mem_req) begin
          if (mem_q.size() == 0) flag("spurious_mem_req");
          else begin
            me = mem_q[0];
            check32("mem_addr", bus.mem_addr, me.addr);
            check32("mem_wen", 32'(bus.mem_wen), 32'(me.wen));
            if (me.wen) begin
              check32("mem_wdata", bus.mem_wdata, me.wdata);
              check32("mem_wmask", 32'(bus.mem_wmask), 32'(me.wmask));
            end
            if (bus.mem_gnt) void'(mem_q.pop_front());
          end
        end
      end
    end
  end

  // Reference expectations for one access, from the lane/extension rules
  task automatic model(input logic wr, input logic rd, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                       input int dg, input int dr, input int t,
                       output resp_exp_t re, output mem_exp_t me, output logic issue);
    int     sz, off, lat;
    logic   access, mis;
    longint v, lane;
    access = wr | rd;
    sz  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    off = (sz == 4) ? 0 : (int'(a % 4) / sz) * sz;
    mis = 1'b0;
`ifdef YSYX_23060096_LSU_MISALIGN_EN
    mis = access && ((a % 32'(sz)) != 0);
`endif
    issue = access && !mis;
    lat = !issue ? 1 : wr ? 2 + dg : 3 + dg + dr;
    v = 0;
    if (issue && !wr) begin
      v = longint'(md >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
      if (sz < 4 && !op[2] && v >= (longint'(1) << (8 * sz - 1)))
        v = v - (longint'(1) << (8 * sz));
    end
    re.rdata = v[31:0];
    re.err   = mis;
    re.at    = t + lat - 1;
    lane = longint'(wd) & ((longint'(1) << (8 * sz)) - 1);
    me.addr  = a - (a % 4);
    me.wen   = wr;
    me.wdata = (sz == 1) ? 32'(lane * 64'h01010101) : (sz == 2) ? 32'(lane * 64'h00010001) : wd;
    me.wmask = 4'(((1 << sz) - 1) << off);
  endtask

  // One access; entered and left at a negedge with the LSU idle
  task automatic do_access(input logic wr, input logic rd, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                           input int dg, input int dr);
    resp_exp_t re;
    mem_exp_t  me;
    logic      issue;
    int        t;
    check32("req_ready_idle", 32'(bus.req_ready), 32'd1);
    t = cyc + 1;
    model(wr, rd, op, a, wd, md, dg, dr, t, re, me, issue);
    resp_q.push_back(re);
    if (issue) mem_q.push_back(me);
    bus.req_valid = 1'b1;
    bus.MemWr = wr;  bus.MemtoReg = rd;  bus.MemOP = op;
    bus.addr = a;    bus.wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.MemWr = 1'($urandom); bus.MemtoReg = 1'($urandom);
    bus.addr = $urandom;      bus.wdata = $urandom;
    if (issue) begin
      for (int i = 0; i < dg; i++) begin
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'($urandom);
        check32("req_ready_busy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
      end
      bus.mem_gnt = 1'b1;
      bus.mem_rvalid = 1'($urandom);
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!wr) begin
        for (int i = 0; i < dr; i++) begin
          bus.mem_gnt = 1'($urandom);
          check32("req_ready_wait", 32'(bus.req_ready), 32'd0);
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = md;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
    for (int i = 0; i < 50 && cyc < re.at + 1; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check32({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check32({tag, "_rdata"}, bus.rdata, 32'd0);
    check32({tag, "_err"}, 32'(bus.err), 32'd0);
    check32({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check32({tag, "_mem_wen"}, 32'(bus.mem_wen), 32'd0);
    check32({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check32({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check32({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
  endtask

  // Reset while waiting for load data; the later rvalid must be ignored
  task automatic reset_in_wait();
    mem_exp_t me;
    me.addr = 32'h80000010; me.wen = 1'b0; me.wdata = '0; me.wmask = '0;
    mem_q.push_back(me);
    bus.req_valid = 1'b1; bus.MemWr = 1'b0; bus.MemtoReg = 1'b1;
    bus.MemOP = 3'b010;   bus.addr = 32'h80000010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check32("rst_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    check_reset_values("post_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] kind;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.MemWr = 1'b0; bus.MemtoReg = 1'b0; bus.MemOP = 3'b000;
    bus.addr = '0; bus.wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    do_access(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h000000AB, 32'h0, 0, 0);
    do_access(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0, 32'h80011234, 0, 0);
    do_access(1'b0, 1'b1, 3'b101, 32'h80000002, 32'h0, 32'h80011234, 1, 1);
    do_access(1'b0, 1'b1, 3'b010, 32'h80000000, 32'h0, 32'hCAFEF00D, 3, 2);
    do_access(1'b0, 1'b0, 3'b010, 32'h80000004, 32'h12345678, 32'h0, 0, 0);
    do_access(1'b1, 1'b1, 3'b001, 32'h80000006, 32'h0000BEEF, 32'h0, 2, 0);
    reset_in_wait();
    do_access(1'b0, 1'b1, 3'b010, 32'h80000002, 32'h0, 32'h89ABCDEF, 0, 0);
    do_access(1'b0, 1'b1, 3'b100, 32'h80000001, 32'h0, 32'h0000F700, 0, 3);
    do_access(1'b0, 1'b1, 3'b000, 32'h80000001, 32'h0, 32'h0000F700, 0, 0);

    for (int n = 0; n < 400; n++) begin
      kind = 2'($urandom);
      do_access(kind[1], kind[0], 3'($urandom), 32'h80000000 | ($urandom % 64),
                $urandom, $urandom, int'($urandom % 4), int'($urandom % 4));
      repeat ($urandom % 2) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check32("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check32("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_lsu.md
# ysyx_23060096_lsu

Load/store unit for the NPC core. It consumes the memory-control fields produced by instruction decode (`MemWr`, `MemtoReg`, `MemOP`) together with the ALU-computed address and rs2 data. It runs a single outstanding access on a valid/grant/rvalid memory port and returns lane-extracted, sign- or zero-extended load data to writeback. It sits between EXU and WBU and stalls the core through `req_ready`/`resp_valid`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; only 32 is supported

Ports:
- `clk` in 1: clock; all state updates on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: EXU presents an access
- `req_ready` out 1: LSU can accept; high only in IDLE
- `MemWr` in 1: store request
- `MemtoReg` in 1: load request
- `MemOP` in 3: access size and extension
  - 000 byte signed
  - 100 byte unsigned
  - 001 half signed
  - 101 half unsigned
  - 010 word
  - other codes treated as word
- `addr` in AW: byte address
- `wdata` in DW: store data, taken from the low bytes
- `resp_valid` out 1: one-cycle completion pulse
- `rdata` out DW: extended load data; 0 for stores and no-ops
- `err` out 1: misalignment flag, qualified by `resp_valid`
- `mem_req` out 1: memory request, held until granted
- `mem_wen` out 1: write enable
- `mem_addr` out AW: word-aligned address (`addr & ~3`)
- `mem_wdata` out DW: store data replicated into byte lanes
- `mem_wmask` out 4: byte-lane strobe
- `mem_gnt` in 1: memory accepts the request
- `mem_rvalid` in 1: read data valid
- `mem_rdata` in DW: raw 32-bit word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch `addr`, `wdata`, `MemOP`, `MemWr`, `MemtoReg`.
  - If `MemWr` or `MemtoReg` is set, go to REQ; otherwise go to RESP (no-op).
- **REQ:**
  - `mem_req`=1; all `mem_*` outputs are stable until `mem_gnt`.
  - On `mem_gnt`: a store goes to RESP, a load goes to WAIT.
- **WAIT:** on `mem_rvalid`, register the extracted/extended data and go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE.
- `MemWr` and `MemtoReg` both set: treated as a store.
- Lane select:
  - byte uses `addr[1:0]`;
  - half uses `addr[1]`;
  - word ignores `addr[1:0]`.
- Store masks:
  - byte: `4'b0001<<addr[1:0]`;
  - half: `4'b0011<<{addr[1],1'b0}`;
  - word: `4'b1111`.
- `mem_wdata`: byte is `{4{wdata[7:0]}}`, half is `{2{wdata[15:0]}}`, word is `wdata`.
- Load extension: signed codes replicate bit 7 or bit 15 of the selected lane; unsigned codes zero-fill.
- `mem_rvalid` outside WAIT is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `rdata`=0, `err`=0, `mem_req`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
- Reset asserted mid-access:
  - `mem_req` drops immediately (asynchronous) and the access is abandoned.
  - A later `mem_rvalid` is ignored.
- Accept at edge T (request latched):
  - `mem_req` is high in cycle T+1.
  - With `mem_gnt` in the first REQ cycle, a store gives `resp_valid` at T+2 (minimum store latency 2).
  - For a load, the earliest legal `mem_rvalid` is T+2, giving `resp_valid` at T+3.
- Each cycle of `mem_gnt` or `mem_rvalid` delay adds one cycle.
- No-op: `resp_valid` at T+1.
- `req_ready` is low from T+1 until the cycle after the RESP pulse.
- Back-to-back request rate is therefore one per (latency+1) cycles.
- `rdata` and `err` hold their values until the next RESP.

## Configuration
- `YSYX_23060096_LSU_MISALIGN_EN` defined:
  - In IDLE, misalignment is detected: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - On detection the FSM goes straight to RESP with `err`=1 and `rdata`=0.
  - `mem_req` is never asserted for the faulting access.
- Macro not defined:
  - `err` is tied to 0.
  - Misaligned accesses are issued using the lane rules above; the low address bits beyond the lane select are ignored.

## Test plan
- Store byte: `addr`=0x80000003, `wdata`=0x000000AB, `MemOP`=000, `mem_gnt` in the first REQ cycle -> `mem_addr`=0x80000000, `mem_wmask`=1000, `mem_wdata`=0xABABABAB, `mem_wen`=1, `resp_valid` 2 cycles after accept.
- Load half signed: `addr`=0x80000002, `mem_rdata`=0x8001_1234, `MemOP`=001 -> `rdata`=0xFFFF8001. Repeat with `MemOP`=101 -> `rdata`=0x00008001.
- Load word with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 cycles -> `mem_req` held with stable outputs for 3 cycles, `resp_valid` a single pulse, `rdata`=`mem_rdata`, `req_ready`=0 throughout.
- No-op (`MemWr`=`MemtoReg`=0) -> no `mem_req`, `resp_valid` at T+1, `rdata`=0.
- Assert `rst` while in WAIT, then drive `mem_rvalid` after release -> all outputs return to reset values, no `resp_valid`.
- With `YSYX_23060096_LSU_MISALIGN_EN`: word load at 0x80000002 -> `err`=1 with `resp_valid` at T+1, `mem_req` never asserted. Without the macro: same stimulus issues `mem_addr`=0x80000000 and `err`=0.
